instruction_register_mw: RTL and testbench

- Parametrised multi-word instruction register, successor to the single-word SAP-1 IR.
- Latches an opcode word from the W bus and presents the opcode to the controller/sequencer.
- Accepts a controller-supplied operand length, then assembles 0..MAX_OPND further operand words from the bus into one operand register.
- Drives a selected operand word back onto the W bus under an active-low enable.

---
 rtl/instruction_register_mw_if.sv | 34 +++
 rtl/instruction_register_mw.sv | 121 ++++++++++++
 tb/tb_instruction_register_mw.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_register_mw_if.sv
// Bus-side signal bundle of the multi-word instruction register.
// master = controller/sequencer side, slave = the IR itself.
interface instruction_register_mw_if #(
  parameter int WORD_W   = 8,
  parameter int OPC_W    = 4,
  parameter int MAX_OPND = 2,
  parameter int LEN_W    = 2
);
  localparam int SEL_W = $clog2(MAX_OPND + 1);

  logic                       nLi;
  logic                       nEi;
  logic [WORD_W-1:0]          wbus;
  logic [LEN_W-1:0]           opnd_len;
  logic [SEL_W-1:0]           esel;
  logic [OPC_W-1:0]           opcode;
  logic [MAX_OPND*WORD_W-1:0] operand;
  logic [WORD_W-1:0]          bus_out;
  logic                       bus_oe;
  logic                       ir_valid;
  logic                       need_more;
  logic [LEN_W-1:0]           opnd_cnt;
  logic                       len_err;

  modport master (
    output nLi, nEi, wbus, opnd_len, esel,
    input  opcode, operand, bus_out, bus_oe, ir_valid, need_more, opnd_cnt, len_err
  );

  modport slave (
    input  nLi, nEi, wbus, opnd_len, esel,
    output opcode, operand, bus_out, bus_oe, ir_valid, need_more, opnd_cnt, len_err
  );
endinterface

// File: rtl/instruction_register_mw.sv
// Multi-word instruction register: opcode word plus 0..MAX_OPND operand words
// assembled from the W bus, with a selectable word driven back onto the bus.
module instruction_register_mw #(
  parameter int WORD_W   = 8,
  parameter int OPC_W    = 4,
  parameter int MAX_OPND = 2,
  parameter int LEN_W    = 2
) (
  input logic                      CLK,
  input logic                      CLR,
  instruction_register_mw_if.slave bus
);
  localparam int SEL_W   = $clog2(MAX_OPND + 1);
  localparam int SHORT_W = WORD_W - OPC_W;

  typedef enum logic [1:0] {EMPTY, OPND, DONE} state_t;

  state_t               state_reg, state_next;
  logic [OPC_W-1:0]     opcode_reg;
  logic [SHORT_W-1:0]   short_reg;
  logic [LEN_W-1:0]     cnt_reg;
  logic [LEN_W-1:0]     len_reg;
  logic                 len_err_reg;

  logic                 opc_load;
  logic                 opnd_load;
  logic                 len_clamp;
  logic [LEN_W-1:0]     len_target;
  logic [WORD_W-1:0]    sel_data;

  wire [MAX_OPND*WORD_W-1:0] operand_flat;
  wire [MAX_OPND-1:0]        word_hit;

  // Any load outside operand assembly starts a fresh instruction.
  assign opc_load   = !bus.nLi && (state_reg != OPND);
  assign opnd_load  = !bus.nLi && (state_reg == OPND);
  assign len_clamp  = ({1'b0, bus.opnd_len} > (LEN_W + 1)'(MAX_OPND));
  assign len_target = len_clamp ? LEN_W'(MAX_OPND) : bus.opnd_len;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY, DONE: begin
        if (opc_load) begin
          state_next = (len_target == '0) ? DONE : OPND;
        end
      end
      OPND: begin
        if (opnd_load && ((cnt_reg + LEN_W'(1)) == len_reg)) begin
          state_next = DONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      opcode_reg  <= '0;
      short_reg   <= '0;
      cnt_reg     <= '0;
      len_reg     <= '0;
      len_err_reg <= 1'b0;
    end else if (opc_load) begin
      opcode_reg  <= bus.wbus[WORD_W-1 -: OPC_W];
      short_reg   <= bus.wbus[SHORT_W-1:0];
      cnt_reg     <= '0;
      len_reg     <= len_target;
      len_err_reg <= len_err_reg | len_clamp;
    end else if (opnd_load) begin
      cnt_reg     <= cnt_reg + LEN_W'(1);
    end
  end

  // One register per operand word; word gi+1 is written while cnt_reg == gi.
  for (genvar gi = 0; gi < MAX_OPND; gi++) begin : g_word
    logic [WORD_W-1:0] word_reg;

    always_ff @(posedge CLK) begin
      if (CLR || opc_load) begin
        word_reg <= '0;
      end else if (opnd_load && (cnt_reg == LEN_W'(gi))) begin
        word_reg <= bus.wbus;
      end
    end

    assign operand_flat[gi*WORD_W +: WORD_W] = word_reg;
    assign word_hit[gi] = (bus.esel == SEL_W'(gi + 1)) && (cnt_reg > LEN_W'(gi));
  end

  always_comb begin
    sel_data = '0;
    if (bus.esel == '0) begin
      sel_data = {{OPC_W{1'b0}}, short_reg};
    end
    for (int i = 0; i < MAX_OPND; i++) begin
      if (word_hit[i]) begin
        sel_data = operand_flat[i*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    bus.opcode    = opcode_reg;
    bus.operand   = operand_flat;
    bus.opnd_cnt  = cnt_reg;
    bus.len_err   = len_err_reg;
    bus.need_more = (state_reg == OPND);
    bus.ir_valid  = (state_reg == DONE);
    bus.bus_oe    = !bus.nEi && ((state_reg == OPND) || (state_reg == DONE));
    bus.bus_out   = bus.bus_oe ? sel_data : '0;
  end
endmodule

// File: tb/tb_instruction_register_mw.sv
// Directed bench for instruction_register_mw: instruction-level model checked
// every cycle, plus literal expectations for the listed scenarios.
module tb_instruction_register_mw;
  localparam int WORD_W   = 8;
  localparam int OPC_W    = 4;
  localparam int MAX_OPND = 2;
  localparam int LEN_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instruction_register_mw_if #(
    .WORD_W(WORD_W), .OPC_W(OPC_W), .MAX_OPND(MAX_OPND), .LEN_W(LEN_W)
  ) ir_bus ();

  instruction_register_mw #(
    .WORD_W(WORD_W), .OPC_W(OPC_W), .MAX_OPND(MAX_OPND), .LEN_W(LEN_W)
  ) dut (
    .CLK(clk),
    .CLR(rst),
    .bus(ir_bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Instruction-level model: an instruction exists once an opcode is taken;
  // it is complete when the captured word count reaches its clamped length.
  bit m_armed = 1'b0;
  bit m_busy;
  bit m_err;
  int m_len, m_cnt, m_opc, m_short;
  int m_w[MAX_OPND+1];

  always @(posedge clk) begin
    if (rst) begin
      m_armed = 1'b1;
      m_busy  = 1'b0;
      m_err   = 1'b0;
      m_len   = 0;
      m_cnt   = 0;
      m_opc   = 0;
      m_short = 0;
      for (int k = 0; k <= MAX_OPND; k++) m_w[k] = 0;
    end else if (m_armed && ir_bus.nLi === 1'b0) begin
      if (!m_busy || m_cnt == m_len) begin
        m_busy  = 1'b1;
        m_opc   = int'(ir_bus.wbus) >> (WORD_W - OPC_W);
        m_short = int'(ir_bus.wbus) % (1 << (WORD_W - OPC_W));
        m_len   = (int'(ir_bus.opnd_len) > MAX_OPND) ? MAX_OPND : int'(ir_bus.opnd_len);
        if (int'(ir_bus.opnd_len) > MAX_OPND) m_err = 1'b1;
        m_cnt   = 0;
        for (int k = 0; k <= MAX_OPND; k++) m_w[k] = 0;
      end else begin
        m_cnt = m_cnt + 1;
        m_w[m_cnt] = int'(ir_bus.wbus);
      end
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      int sel, data, op;
      bit oe;
      sel = int'(ir_bus.esel);
      if (sel == 0) data = m_short;
      else if (sel <= MAX_OPND && sel <= m_cnt) data = m_w[sel];
      else data = 0;
      oe = (ir_bus.nEi === 1'b0) && m_busy;
      op = 0;
      for (int k = 1; k <= MAX_OPND; k++) op = op | (m_w[k] << (WORD_W * (k - 1)));
      check("cyc_opcode",    32'(ir_bus.opcode),    32'(m_opc));
      check("cyc_operand",   32'(ir_bus.operand),   32'(op));
      check("cyc_opnd_cnt",  32'(ir_bus.opnd_cnt),  32'(m_cnt));
      check("cyc_ir_valid",  32'(ir_bus.ir_valid),  32'(m_busy && m_cnt == m_len));
      check("cyc_need_more", 32'(ir_bus.need_more), 32'(m_busy && m_cnt < m_len));
      check("cyc_len_err",   32'(ir_bus.len_err),   32'(m_err));
      check("cyc_bus_oe",    32'(ir_bus.bus_oe),    32'(oe));
      check("cyc_bus_out",   32'(ir_bus.bus_out),   oe ? 32'(data) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WORD_W-1:0] w, input logic [LEN_W-1:0] len);
    ir_bus.nLi      = 1'b0;
    ir_bus.wbus     = w;
    ir_bus.opnd_len = len;
    tick();
    ir_bus.nLi  = 1'b1;
    ir_bus.wbus = 'x;
  endtask

  initial begin
    ir_bus.nLi      = 1'b1;
    ir_bus.nEi      = 1'b1;
    ir_bus.wbus     = '0;
    ir_bus.opnd_len = '0;
    ir_bus.esel     = '0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_opcode",   32'(ir_bus.opcode),   32'h0);
    check("rst_operand",  32'(ir_bus.operand),  32'h0);
    check("rst_ir_valid", 32'(ir_bus.ir_valid), 32'h0);
    check("rst_len_err",  32'(ir_bus.len_err),  32'h0);
    ir_bus.nEi = 1'b0;
    #1;
    check("empty_bus_oe", 32'(ir_bus.bus_oe), 32'h0);
    ir_bus.nEi = 1'b1;

    // single-word instruction
    load(8'h3A, 2'd0);
    check("t1_opcode",    32'(ir_bus.opcode),    32'h3);
    check("t1_ir_valid",  32'(ir_bus.ir_valid),  32'h1);
    check("t1_need_more", 32'(ir_bus.need_more), 32'h0);
    ir_bus.nEi  = 1'b0;
    ir_bus.esel = 2'd0;
    #1;
    check("t1_bus_out", 32'(ir_bus.bus_out), 32'h0A);
    check("t1_bus_oe",  32'(ir_bus.bus_oe),  32'h1);
    ir_bus.nEi = 1'b1;

    // two-operand instruction with idle gaps
    load(8'hC0, 2'd2);
    check("t2_need_more0", 32'(ir_bus.need_more), 32'h1);
    for (int i = 0; i < 3; i++) begin
      ir_bus.nEi  = 1'b0;
      ir_bus.esel = 2'd1;
      tick();
      check("t2_idle_need_more", 32'(ir_bus.need_more), 32'h1);
      check("t2_idle_bus_out",   32'(ir_bus.bus_out),   32'h0);
    end
    ir_bus.nEi = 1'b1;
    load(8'h34, 2'd0);
    check("t2_cnt1", 32'(ir_bus.opnd_cnt), 32'h1);
    load(8'h12, 2'd0);
    check("t2_operand",  32'(ir_bus.operand),  32'h1234);
    check("t2_cnt2",     32'(ir_bus.opnd_cnt), 32'h2);
    check("t2_ir_valid", 32'(ir_bus.ir_valid), 32'h1);
    ir_bus.nEi  = 1'b0;
    ir_bus.esel = 2'd2;
    #1;
    check("t2_bus_out_w2", 32'(ir_bus.bus_out), 32'h12);

    // simultaneous load and drive
    ir_bus.nLi      = 1'b0;
    ir_bus.wbus     = 8'h55;
    ir_bus.opnd_len = 2'd0;
    ir_bus.esel     = 2'd1;
    #1;
    check("t5_bus_out_pre", 32'(ir_bus.bus_out), 32'h34);
    tick();
    ir_bus.nLi = 1'b1;
    ir_bus.nEi = 1'b1;
    check("t5_opcode",  32'(ir_bus.opcode),  32'h5);
    check("t5_operand", 32'(ir_bus.operand), 32'h0);

    // length clamp
    load(8'hE1, 2'd3);
    check("t3_len_err",   32'(ir_bus.len_err),   32'h1);
    check("t3_need_more", 32'(ir_bus.need_more), 32'h1);
    load(8'hAA, 2'd0);
    check("t3_need_more1", 32'(ir_bus.need_more), 32'h1);
    load(8'hBB, 2'd0);
    check("t3_ir_valid", 32'(ir_bus.ir_valid), 32'h1);
    check("t3_operand",  32'(ir_bus.operand),  32'hBBAA);
    load(8'h10, 2'd0);
    check("t3_len_err_sticky", 32'(ir_bus.len_err), 32'h1);
    check("t3_opcode_next",    32'(ir_bus.opcode),  32'h1);

    // reset mid-assembly
    load(8'hC0, 2'd2);
    load(8'h77, 2'd0);
    check("t4_cnt1", 32'(ir_bus.opnd_cnt), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_opcode",    32'(ir_bus.opcode),    32'h0);
    check("t4_operand",   32'(ir_bus.operand),   32'h0);
    check("t4_need_more", 32'(ir_bus.need_more), 32'h0);
    check("t4_len_err",   32'(ir_bus.len_err),   32'h0);
    load(8'h91, 2'd0);
    check("t4_new_opcode", 32'(ir_bus.opcode),   32'h9);
    check("t4_new_valid",  32'(ir_bus.ir_valid), 32'h1);

    // out-of-range select after a one-operand instruction
    load(8'h20, 2'd1);
    load(8'h44, 2'd0);
    ir_bus.nEi  = 1'b0;
    ir_bus.esel = 2'd2;
    #1;
    check("t6_bus_out_sel2", 32'(ir_bus.bus_out), 32'h0);
    check("t6_bus_oe",       32'(ir_bus.bus_oe),  32'h1);
    ir_bus.esel = 2'd3;
    #1;
    check("t6_bus_out_sel3", 32'(ir_bus.bus_out), 32'h0);
    ir_bus.esel = 2'd1;
    #1;
    check("t6_bus_out_sel1", 32'(ir_bus.bus_out), 32'h44);
    ir_bus.nEi = 1'b1;

    // reset wins over a simultaneous load
    rst         = 1'b1;
    ir_bus.nLi  = 1'b0;
    ir_bus.wbus = 8'hFF;
    tick();
    rst        = 1'b0;
    ir_bus.nLi = 1'b1;
    check("rstpri_opcode", 32'(ir_bus.opcode),   32'h0);
    check("rstpri_valid",  32'(ir_bus.ir_valid), 32'h0);
    ir_bus.nEi = 1'b0;
    #1;
    check("rstpri_bus_oe", 32'(ir_bus.bus_oe), 32'h0);
    ir_bus.nEi = 1'b1;

    tick();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
